// File: rtl/serial_iter_compare_ctrl.sv
// Bit-serial unsigned comparator: evaluates Z = (A <= B) one cell per clock, MSB first,
// keeping the left-to-right (p,q) carry pair in registers and applying the final cell on bit 0.
module serial_iter_compare_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             z
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             p_q, p_d;
  logic             q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             z_q, z_d;
  logic             ai, bi;

  // p: A<B already decided by a higher bit; q: A>B not yet decided.
  function automatic logic [1:0] cell_step(input logic p, input logic q,
                                           input logic abit, input logic bbit);
    logic p_n;
    logic q_n;
    p_n = p | (q & ~abit & bbit);
    q_n = q & (p | ~abit | bbit);
    return {p_n, q_n};
  endfunction

  function automatic logic cell_final(input logic p, input logic q,
                                      input logic abit, input logic bbit);
    return q & (p | ~abit | bbit);
  endfunction

  assign ai = a_q[idx_q];
  assign bi = b_q[idx_q];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    p_d     = p_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          p_d     = 1'b0;
          q_d     = 1'b1;
          idx_d   = CNT_W'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // No early exit: every operation takes exactly WIDTH cycles.
        if (idx_q != '0) begin
          {p_d, q_d} = cell_step(p_q, q_q, ai, bi);
          idx_d      = idx_q - 1'b1;
        end else begin
          z_d     = cell_final(p_q, q_q, ai, bi);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      p_q     <= 1'b0;
      q_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      z_q     <= z_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;

endmodule

// File: tb/tb_serial_iter_compare_ctrl.sv
// Directed bench for serial_iter_compare_ctrl at WIDTH=8 and WIDTH=2, sharing one clock and reset.
module tb_serial_iter_compare_ctrl;

  logic       clk;
  logic       rst;
  logic       start8, busy8, done8, z8;
  logic [7:0] a8, b8;
  logic       start2, busy2, done2, z2;
  logic [1:0] a2, b2;

  int n_tests = 0;
  int n_fail  = 0;

  serial_iter_compare_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .z(z8)
  );

  serial_iter_compare_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .z(z2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : busy2;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : done2;
  endfunction

  function automatic logic get_z(input int w);
    return (w == 8) ? z8 : z2;
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv);
    if (w == 8) begin
      start8 = s; a8 = av; b8 = bv;
    end else begin
      start2 = s; a2 = av[1:0]; b2 = bv[1:0];
    end
  endtask

  // One complete operation: start for one cycle, then scramble the operands to
  // prove they were captured, and check busy length, done position and z.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic ez, input string tag);
    int bc;
    int dc;
    bc = 0;
    dc = 0;
    @(negedge clk);
    drive(w, 1'b1, av, bv);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      if (i == 0) drive(w, 1'b0, ~av, ~bv);
      bc += int'(get_busy(w));
      dc += int'(get_done(w));
    end
    check({tag, "_busycyc"}, bc, w);
    check({tag, "_earlydone"}, dc, 0);
    @(negedge clk);
    check({tag, "_done"}, get_done(w), 1'b1);
    check({tag, "_busyoff"}, get_busy(w), 1'b0);
    check({tag, "_z"}, get_z(w), ez);
    @(negedge clk);
    check({tag, "_donepulse"}, get_done(w), 1'b0);
    check({tag, "_zhold"}, get_z(w), ez);
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    drive(8, 1'b0, 8'h00, 8'h00);
    drive(2, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_z8", z8, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    check("rst_z2", z2, 1'b0);
    rst = 1'b0;

    // WIDTH=8 directed vectors
    run_op(8, 8'h5A, 8'h5A, 1'b1, "w8_eq");
    run_op(8, 8'h80, 8'h7F, 1'b0, "w8_msb_gt");
    run_op(8, 8'h7F, 8'h80, 1'b1, "w8_msb_lt");
    run_op(8, 8'h01, 8'h00, 1'b0, "w8_lsb_gt");
    run_op(8, 8'h00, 8'h01, 1'b1, "w8_lsb_lt");
    run_op(8, 8'hFF, 8'hFF, 1'b1, "w8_ones");
    run_op(8, 8'hC3, 8'hC2, 1'b0, "w8_c3c2");

    // WIDTH=2 directed vectors
    run_op(2, 8'h02, 8'h01, 1'b0, "w2_10_01");
    run_op(2, 8'h01, 8'h02, 1'b1, "w2_01_10");
    run_op(2, 8'h03, 8'h03, 1'b1, "w2_eq");
    run_op(2, 8'h01, 8'h00, 1'b0, "w2_lsb_gt");
    run_op(2, 8'h00, 8'h01, 1'b1, "w2_lsb_lt");

    // start held high through a run with operands changed mid-run, then back-to-back
    @(negedge clk);
    drive(8, 1'b1, 8'h80, 8'h7F);
    dc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) drive(8, 1'b1, 8'h00, 8'hFF);
      dc += int'(done8);
    end
    check("hold_nodone", dc, 0);
    @(negedge clk);
    check("hold_done", done8, 1'b1);
    check("hold_z_first", z8, 1'b0);
    check("hold_busy", busy8, 1'b0);
    drive(8, 1'b1, 8'h00, 8'h01);
    dc = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        drive(8, 1'b0, 8'hFF, 8'h00);
        check("b2b_busy", busy8, 1'b1);
      end
      dc += int'(done8);
    end
    check("b2b_nodone", dc, 0);
    @(negedge clk);
    check("b2b_done", done8, 1'b1);
    check("b2b_z", z8, 1'b1);

    // reset mid-run at T0+4
    @(negedge clk);
    drive(8, 1'b1, 8'h80, 8'h7F);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy8, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy8, 1'b0);
    check("midrst_done", done8, 1'b0);
    check("midrst_z", z8, 1'b0);
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dc += int'(done8) + int'(busy8);
    end
    check("midrst_quiet", dc, 0);
    run_op(8, 8'h12, 8'h34, 1'b1, "w8_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
